// File: rtl/cache_refill_ctrl.sv
// Cache miss controller: on a miss, write back a dirty victim block, refill
// the missing block one word beat at a time, then install the new tag.
// Holds the pipeline stalled for the whole sequence and counts misses.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cache_enable_i,
  input  logic                           lookup_i,
  input  logic                           hit_i,
  input  logic                           dirty_i,
  input  logic [DATA_WIDTH-1:0]          address_i,
  input  logic [DATA_WIDTH-1:0]          victim_addr_i,
  input  logic                           mem_ack_i,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [DATA_WIDTH-1:0]          mem_addr_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] wb_word_o,
  output logic                           fill_we_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_o,
  output logic                           tag_we_o,
  output logic                           stall_o,
  output logic [15:0]                    miss_count_o
);

  localparam int BW  = $clog2(BLOCK_WORDS);
  localparam int OFF = BW + 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [DATA_WIDTH-OFF-1:0] miss_base_q, miss_base_d;
  logic [DATA_WIDTH-1:0]     victim_q, victim_d;
  logic [15:0]               miss_count_q, miss_count_d;
  logic                      miss;
  logic                      last_beat;
  logic                      unused_offset;

  // Counter stops at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Word-offset bits of the access address never leave the controller.
  assign unused_offset = ^address_i[OFF-1:0];

  assign miss      = (state_q == IDLE) & cache_enable_i & lookup_i & ~hit_i;
  assign last_beat = (beat_q == LAST_BEAT);

  assign miss_count_o = miss_count_q;

  // Next-state, latch updates and beat outputs.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    miss_base_d  = miss_base_q;
    victim_d     = victim_q;
    miss_count_d = miss_count_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    wb_word_o    = '0;
    fill_we_o    = 1'b0;
    fill_word_o  = '0;
    tag_we_o     = 1'b0;
    stall_o      = miss;
    case (state_q)
      IDLE: begin
        if (miss) begin
          miss_base_d  = address_i[DATA_WIDTH-1:OFF];
          victim_d     = victim_addr_i;
          beat_d       = '0;
          miss_count_d = sat_inc(miss_count_q);
          state_d      = dirty_i ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = victim_q | DATA_WIDTH'({beat_q, 2'b00});
        wb_word_o  = beat_q;
        if (mem_ack_i) begin
          // The increment wraps to zero exactly on the last beat.
          beat_d = beat_q + BW'(1);
          if (last_beat) state_d = REFILL;
        end
      end
      REFILL: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {miss_base_q, beat_q, 2'b00};
        fill_we_o   = mem_ack_i;
        fill_word_o = beat_q;
        if (mem_ack_i) begin
          beat_d = beat_q + BW'(1);
          if (last_beat) state_d = UPDATE;
        end
      end
      UPDATE: begin
        stall_o  = 1'b1;
        tag_we_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, beat counter, latched addresses and miss counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      miss_base_q  <= '0;
      victim_q     <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      miss_base_q  <= miss_base_d;
      victim_q     <= victim_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning datapath word and address width.
REQ-002 SHALL have parameter BLOCK_WORDS, default 4, meaning words per cache block (power of two, >=2); OFF = log2(BLOCK_WORDS)+2 address offset bits.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  clock, all state on rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 cache_enable_i  input  1  cache active; low means every access bypasses and no miss handling occurs.
REQ-006 lookup_i  input  1  datapath load/store access valid this cycle.
REQ-007 hit_i  input  1  cache tag compare result for the current access.
REQ-008 dirty_i  input  1  victim line dirty.
REQ-009 address_i  input  DATA_WIDTH  access address from the ALU result.
REQ-010 victim_addr_i  input  DATA_WIDTH  block base address of the victim line.
REQ-011 mem_ack_i  input  1  main memory completed one word beat.
REQ-012 mem_req_o  output  1  memory beat request.
REQ-013 mem_we_o  output  1  beat is a write (writeback).
REQ-014 mem_addr_o  output  DATA_WIDTH  word address of the current beat.
REQ-015 wb_word_o  output  log2(BLOCK_WORDS)  victim word index to drive onto memory write data.
REQ-016 fill_we_o  output  1  write the returned memory word into the cache line.
REQ-017 fill_word_o  output  log2(BLOCK_WORDS)  cache word index for fill_we_o.
REQ-018 tag_we_o  output  1  install new tag, set valid, clear dirty.
REQ-019 stall_o  output  1  freeze PC and pipeline registers.
REQ-020 miss_count_o  output  16  saturating miss counter.

Function
REQ-021 SHALL implement states IDLE, WRITEBACK, REFILL, UPDATE with a beat counter of log2(BLOCK_WORDS) bits.
REQ-022 Miss = cache_enable_i & lookup_i & ~hit_i, evaluated only in IDLE.
REQ-023 IDLE on miss: latch address_i[DATA_WIDTH-1:OFF] as miss base, latch victim_addr_i, clear the beat counter; go to WRITEBACK if dirty_i, else REFILL.
REQ-024 stall_o = miss (combinational, in IDLE) OR state != IDLE.
REQ-025 WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o = victim base | (beat<<2), wb_word_o = beat; each mem_ack_i increments beat; ack on the last beat goes to REFILL with beat=0.
REQ-026 REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o = {miss base, beat, 2'b00}; fill_we_o = mem_ack_i in the same cycle, fill_word_o = beat; ack on the last beat goes to UPDATE.
REQ-027 UPDATE: tag_we_o=1 for exactly one cycle; stall_o=1; then IDLE, where the datapath replays the access and hits.
REQ-028 mem_req_o, mem_we_o and mem_addr_o SHALL stay stable from assertion until mem_ack_i; no beat is skipped or repeated.
REQ-029 mem_ack_i in IDLE or UPDATE SHALL be ignored.
REQ-030 miss_count_o increments by 1 on each IDLE miss and saturates at 16'hFFFF.
REQ-031 A lookup_i with cache_enable_i=0 SHALL never stall and SHALL never count.
REQ-032 Changes on cache_enable_i, lookup_i, hit_i or dirty_i outside IDLE SHALL NOT alter the sequence in progress.
REQ-033 Beat counter wrap from BLOCK_WORDS-1 to 0 SHALL coincide only with the state exit.

Reset
REQ-034 When rst_ni is low, the block SHALL immediately (asynchronously) enter IDLE, and all registered state SHALL be cleared: beat=0, latched addresses=0, miss_count_o=0.
REQ-035 During reset, mem_req_o, mem_we_o, fill_we_o, tag_we_o, wb_word_o, fill_word_o and mem_addr_o SHALL be 0.
REQ-036 During reset, stall_o SHALL be driven only by the combinational miss term.
REQ-037 Reset asserted mid-WRITEBACK or mid-REFILL SHALL drop mem_req_o in the same cycle; no partial fill completes tag_we_o.

Verification
REQ-038 Clean miss: address_i=0x0000_1234, hit_i=0, dirty_i=0, ack every cycle -> read addrs 0x1230, 0x1234, 0x1238, 0x123C; fill_word 0..3; one tag_we_o; stall high 6 cycles; miss_count_o=1.
REQ-039 Dirty miss: victim_addr_i=0x0000_8000 -> write beats 0x8000..0x800C with wb_word 0..3, then refill beats; mem_we_o=1 only during writeback.
REQ-040 Slow memory: ack every 3rd cycle -> mem_addr_o is held 3 cycles per beat; total stall = 4*3+2 cycles.
REQ-041 Bypass and hit: cache_enable_i=0 with hit_i=0 -> stall_o=0, no mem_req_o; cache_enable_i=1 with hit_i=1 -> stall_o=0, count unchanged.
REQ-042 Reset mid-REFILL after 2 beats -> mem_req_o=0 immediately, state IDLE, no tag_we_o, miss_count_o=0.
REQ-043 Saturation: preload 0xFFFE misses -> after 3 more misses, miss_count_o=0xFFFF.
